id_hazard_stage: RTL

Decode-side neighbour of the fetch stage. Holds the IF/ID pipeline register and resolves beq/bne/j/jal/jr in ID. Drives the fetch stage's stall and redirect inputs (hazard, PCSrc, BranchTaken, PCBranch, jumpAddress, jumpReg). Detects load-use and branch-operand hazards, and presents a bubble indication to ID/EX.

---
 rtl/id_hazard_stage_pkg.sv | 46 ++++
 rtl/id_hazard_stage_if.sv | 33 +++
 rtl/id_hazard_stage_if_id_reg.sv | 52 +++++
 rtl/id_hazard_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/id_hazard_stage_pkg.sv
// ============================================================================
// id_hazard_stage_pkg : opcode/funct constants, PCSrc encoding, NOP, decoder
// Revision 1.0
// ============================================================================
`default_nettype none

package id_hazard_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_JUMP = 2'b10,
    PCSRC_JREG = 2'b11
  } pcsrc_e;

  typedef struct packed {
    logic is_jr;
    logic is_jump;
    logic is_beq;
    logic is_bne;
    logic uses_rt;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.is_jr   = (op == OP_RTYPE) && (funct == FUNCT_JR);
    d.is_jump = (op == OP_J) || (op == OP_JAL);
    d.is_beq  = (op == OP_BEQ);
    d.is_bne  = (op == OP_BNE);
    d.uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_hazard_stage_if.sv
// ============================================================================
// id_hazard_stage_if : fetch <-> decode bus (PC+4/instruction in, stall/redirect out)
// Revision 1.0
// ============================================================================
`default_nettype none

interface id_hazard_stage_if #(
  parameter int DATA_W = 32
);
  import id_hazard_stage_pkg::*;

  logic [DATA_W-1:0] contador;
  logic [DATA_W-1:0] instrucao;
  logic              hazard;
  pcsrc_e            PCSrc;
  logic              BranchTaken;
  logic [DATA_W-1:0] PCBranch;
  logic [DATA_W-1:0] jumpAddress;
  logic [DATA_W-1:0] jumpReg;

  modport master (
    output contador, instrucao,
    input  hazard, PCSrc, BranchTaken, PCBranch, jumpAddress, jumpReg
  );

  modport slave (
    input  contador, instrucao,
    output hazard, PCSrc, BranchTaken, PCBranch, jumpAddress, jumpReg
  );

endinterface

`default_nettype wire

// File: rtl/id_hazard_stage_if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with reset > hold > flush > load priority
// Revision 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import id_hazard_stage_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_hold,
  input  wire logic              i_flush,
  input  wire logic [DATA_W-1:0] i_instr,
  input  wire logic [DATA_W-1:0] i_pc4,
  output logic      [DATA_W-1:0] o_instr,
  output logic      [DATA_W-1:0] o_pc4,
  output logic                   o_valid
);

  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_pc4;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      // A flush still tracks the fetch PC so the bubble carries a sane PC+4.
      r_pc4 <= i_pc4;
      if (i_flush) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else begin
        r_instr <= i_instr;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/id_hazard_stage.sv
// ============================================================================
// id_hazard_stage : IF/ID register, ID-stage branch/jump resolution, hazard detect
// Revision 1.0 -- optional counters under `PERF_CNT_EN`
// ============================================================================
`default_nettype none

module id_hazard_stage
  import id_hazard_stage_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                REG_W     = 5,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  wire logic              clock,
  input  wire logic              reset,
  id_hazard_stage_if.slave       fetch,
  input  wire logic [DATA_W-1:0] rs_data,
  input  wire logic [DATA_W-1:0] rt_data,
  input  wire logic              ex_mem_read,
  input  wire logic              ex_reg_write,
  input  wire logic [REG_W-1:0]  ex_dst,
  input  wire logic              mem_mem_read,
  input  wire logic [REG_W-1:0]  mem_dst,
  output logic      [REG_W-1:0]  rs_addr,
  output logic      [REG_W-1:0]  rt_addr,
  output logic      [DATA_W-1:0] id_instr,
  output logic      [DATA_W-1:0] id_pc4,
  output logic                   id_valid,
  output logic                   id_bubble
`ifdef PERF_CNT_EN
  ,
  output logic      [31:0]       stall_cycles,
  output logic      [31:0]       flush_count
`endif
);

  logic [DATA_W-1:0] w_instr;
  logic [DATA_W-1:0] w_pc4;
  logic              w_valid;
  dec_t              w_dec;
  logic [REG_W-1:0]  w_rs;
  logic [REG_W-1:0]  w_rt;
  logic              w_ex_rs_hit;
  logic              w_ex_rt_hit;
  logic              w_mem_rs_hit;
  logic              w_mem_rt_hit;
  logic              w_load_use;
  logic              w_is_branch;
  logic              w_branch_hz;
  logic              w_hazard;
  logic              w_resolve;
  logic              w_taken;
  pcsrc_e            w_pcsrc;
  logic              w_redirect;
  logic [DATA_W-1:0] w_imm_ext;

  if_id_reg #(
    .DATA_W    (DATA_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clock),
    .rst     (reset),
    .i_hold  (w_hazard),
    .i_flush (w_redirect),
    .i_instr (fetch.instrucao),
    .i_pc4   (fetch.contador),
    .o_instr (w_instr),
    .o_pc4   (w_pc4),
    .o_valid (w_valid)
  );

  assign w_dec = decode(w_instr[31:26], w_instr[5:0]);
  assign w_rs  = w_instr[25:21];
  assign w_rt  = w_instr[20:16];

  // Register 0 is hard-wired, so a zero destination never creates a dependency.
  assign w_ex_rs_hit  = (ex_dst != '0)  && (ex_dst == w_rs);
  assign w_ex_rt_hit  = (ex_dst != '0)  && (ex_dst == w_rt);
  assign w_mem_rs_hit = (mem_dst != '0) && (mem_dst == w_rs);
  assign w_mem_rt_hit = (mem_dst != '0) && (mem_dst == w_rt);

  assign w_load_use = ex_mem_read && (w_ex_rs_hit || (w_dec.uses_rt && w_ex_rt_hit));

  // jr only reads rs; beq/bne compare both operands in ID.
  assign w_is_branch = w_dec.is_beq || w_dec.is_bne;
  assign w_branch_hz =
      (w_is_branch && ((ex_reg_write && (w_ex_rs_hit || w_ex_rt_hit)) ||
                       (mem_mem_read && (w_mem_rs_hit || w_mem_rt_hit)))) ||
      (w_dec.is_jr && ((ex_reg_write && w_ex_rs_hit) || (mem_mem_read && w_mem_rs_hit)));

  assign w_hazard  = w_valid && (w_load_use || w_branch_hz);
  assign w_resolve = w_valid && !w_hazard;

  assign w_taken = w_resolve &&
                   ((w_dec.is_beq && (rs_data == rt_data)) ||
                    (w_dec.is_bne && (rs_data != rt_data)));

  always_comb begin
    w_pcsrc = PCSRC_SEQ;
    if (w_resolve) begin
      if (w_dec.is_jump) begin
        w_pcsrc = PCSRC_JUMP;
      end else if (w_dec.is_jr) begin
        w_pcsrc = PCSRC_JREG;
      end
    end
  end

  assign w_redirect = w_taken || (w_pcsrc != PCSRC_SEQ);
  assign w_imm_ext  = {{(DATA_W-16){w_instr[15]}}, w_instr[15:0]};

  assign fetch.hazard      = w_hazard;
  assign fetch.PCSrc       = w_pcsrc;
  assign fetch.BranchTaken = w_taken;
  assign fetch.PCBranch    = w_pc4 + (w_imm_ext << 2);
  assign fetch.jumpAddress = {w_pc4[DATA_W-1:DATA_W-4], w_instr[25:0], 2'b00};
  assign fetch.jumpReg     = rs_data;

  assign rs_addr   = w_rs;
  assign rt_addr   = w_rt;
  assign id_instr  = w_instr;
  assign id_pc4    = w_pc4;
  assign id_valid  = w_valid;
  assign id_bubble = w_hazard || !w_valid;

`ifdef PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_hazard) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_redirect) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

`default_nettype wire
